// File: rtl/pwm_pkg.sv
// Shared definitions for blocks that work in step with the 256-cycle PWM period.
package pwm_pkg;
  localparam int PWM_W      = 8;
  localparam int PWM_PERIOD = 256;
  localparam int DIV_W      = 4;

  typedef enum logic {
    IDLE,
    RAMP
  } ramp_state_e;
endpackage

// File: rtl/pwm_duty_ramp_if.sv
// Target handshake, halt request and duty/status outputs of the duty ramp sequencer.
interface pwm_duty_ramp_if;
  import pwm_pkg::*;

  logic [PWM_W-1:0] target;
  logic             target_valid;
  logic             target_ready;
  logic             halt;
  logic [PWM_W-1:0] duty_out;
  logic             busy;
  logic             done;

  modport master (
    output target, target_valid, halt,
    input  target_ready, duty_out, busy, done
  );

  modport slave (
    input  target, target_valid, halt,
    output target_ready, duty_out, busy, done
  );
endinterface

// File: rtl/pwm_period_tick.sv
// Free-running phase counter locked to the PWM generator, plus a DIV-period prescaler
// producing a boundary pulse every period and a step_tick pulse every DIV periods.
module pwm_period_tick
  import pwm_pkg::*;
#(
  parameter int DIV = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  output logic boundary,
  output logic step_tick
);

  localparam logic [PWM_W-1:0] PHASE_LAST = PWM_W'(PWM_PERIOD - 1);
  localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(DIV - 1);

  logic [PWM_W-1:0] phase;
  logic [DIV_W-1:0] div_cnt;

  assign boundary  = (phase == PHASE_LAST);
  assign step_tick = boundary && (div_cnt == DIV_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase   <= '0;
      div_cnt <= '0;
    end else begin
      phase <= phase + 1'b1;
      if (clear) begin
        div_cnt <= '0;
      end else if (step_tick) begin
        div_cnt <= '0;
      end else if (boundary) begin
        div_cnt <= div_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/pwm_duty_ramp.sv
// Soft-start / slew-limited duty sequencer driving a PWM generator's pwm_in.
// Optional macro PWM_RAMP_CLAMP_EN limits accepted targets (and so duty_out) to MAX_DUTY.
module pwm_duty_ramp
  import pwm_pkg::*;
#(
  parameter int STEP     = 1,
  parameter int DIV      = 1,
  parameter int MAX_DUTY = 255
) (
  input logic            clk,
  input logic            rst_n,
  pwm_duty_ramp_if.slave ctrl
);

  if (STEP < 1 || STEP > 255 || DIV < 1 || DIV > 16 || MAX_DUTY < 0 || MAX_DUTY > 255)
  begin : g_param_check
    $error("pwm_duty_ramp: parameter out of range");
  end

  localparam logic [PWM_W-1:0] STEP_8 = PWM_W'(STEP);
  localparam logic [PWM_W:0]   STEP_9 = (PWM_W + 1)'(STEP);

  function automatic logic [PWM_W-1:0] limit_target(input logic [PWM_W-1:0] t);
`ifdef PWM_RAMP_CLAMP_EN
    if (t > PWM_W'(MAX_DUTY)) return PWM_W'(MAX_DUTY);
`endif
    return t;
  endfunction

  ramp_state_e             state;
  logic        [PWM_W-1:0] duty;
  logic        [PWM_W-1:0] tgt;
  logic        [PWM_W-1:0] tgt_in;
  logic                    ready;
  logic                    busy;
  logic                    done;
  logic                    halt_pend;
  logic                    halt_now;
  logic                    accept;
  logic                    clear;
  logic                    boundary;
  logic                    step_tick;
  logic signed [PWM_W:0]   delta;
  logic        [PWM_W:0]   gap;
  logic                    last_step;

  assign accept   = ready && ctrl.target_valid;
  assign halt_now = halt_pend || ctrl.halt;
  assign tgt_in   = limit_target(ctrl.target);
  assign clear    = accept || (boundary && halt_now);

  // Distance to target in 9 bits; a step only moves by STEP when it cannot overshoot.
  assign delta     = $signed({1'b0, tgt}) - $signed({1'b0, duty});
  assign gap       = delta[PWM_W] ? $unsigned(-delta) : $unsigned(delta);
  assign last_step = (gap <= STEP_9);

  pwm_period_tick #(
    .DIV (DIV)
  ) u_tick (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (clear),
    .boundary  (boundary),
    .step_tick (step_tick)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      ready     <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
      halt_pend <= 1'b0;
      duty      <= '0;
      tgt       <= '0;
    end else begin
      done      <= 1'b0;
      halt_pend <= halt_now && !boundary;
      // A halt landing on a boundary wins over any step or same-cycle handshake.
      if (boundary && halt_now) begin
        duty  <= '0;
        tgt   <= '0;
        state <= IDLE;
        ready <= 1'b1;
        busy  <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (accept) begin
              tgt <= tgt_in;
              if (tgt_in != duty) begin
                state <= RAMP;
                ready <= 1'b0;
                busy  <= 1'b1;
              end else begin
                done <= 1'b1;
              end
            end
          end
          RAMP: begin
            if (step_tick) begin
              if (last_step) begin
                duty  <= tgt;
                done  <= 1'b1;
                state <= IDLE;
                ready <= 1'b1;
                busy  <= 1'b0;
              end else begin
                duty <= delta[PWM_W] ? duty - STEP_8 : duty + STEP_8;
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign ctrl.target_ready = ready;
  assign ctrl.duty_out     = duty;
  assign ctrl.busy         = busy;
  assign ctrl.done         = done;

endmodule
